// File: rtl/eth_tx_arbiter.sv
// Two-requester arbiter in front of eth_axis_tx: grants one requester per frame and muxes header and payload.
// Define ETH_TX_ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise requester 0 wins ties.
module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_hdr_valid,
    output logic                  req0_hdr_ready,
    input  logic [47:0]           req0_dest_mac,
    input  logic [47:0]           req0_src_mac,
    input  logic [15:0]           req0_eth_type,
    input  logic [DATA_WIDTH-1:0] req0_tdata,
    input  logic                  req0_tvalid,
    input  logic                  req0_tlast,
    input  logic                  req0_tuser,
    output logic                  req0_tready,
    input  logic                  req1_hdr_valid,
    output logic                  req1_hdr_ready,
    input  logic [47:0]           req1_dest_mac,
    input  logic [47:0]           req1_src_mac,
    input  logic [15:0]           req1_eth_type,
    input  logic [DATA_WIDTH-1:0] req1_tdata,
    input  logic                  req1_tvalid,
    input  logic                  req1_tlast,
    input  logic                  req1_tuser,
    output logic                  req1_tready,
    output logic                  tx_s_eth_hdr_valid,
    input  logic                  tx_s_eth_hdr_ready,
    output logic [47:0]           tx_s_eth_dest_mac,
    output logic [47:0]           tx_s_eth_src_mac,
    output logic [15:0]           tx_s_eth_type,
    output logic [DATA_WIDTH-1:0] tx_s_eth_payload_axis_tdata,
    output logic                  tx_s_eth_payload_axis_tvalid,
    output logic                  tx_s_eth_payload_axis_tlast,
    output logic                  tx_s_eth_payload_axis_tuser,
    input  logic                  tx_s_eth_payload_axis_tready,
    input  logic                  tx_busy,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t     r_state;
    logic [1:0] r_grant;
    logic       w_sel;
    logic       w_hdr_valid;
    logic       w_tvalid;
    logic       w_tlast;
    logic       w_any_req;
    logic       w_winner;
    logic       w_frame_end;

    assign w_sel       = r_grant[1];
    assign w_hdr_valid = w_sel ? req1_hdr_valid : req0_hdr_valid;
    assign w_tvalid    = w_sel ? req1_tvalid : req0_tvalid;
    assign w_tlast     = w_sel ? req1_tlast : req0_tlast;
    assign w_any_req   = req0_hdr_valid | req1_hdr_valid;
    assign w_frame_end = (r_state == PAYLOAD) && w_tvalid && tx_s_eth_payload_axis_tready && w_tlast;
    assign grant       = r_grant;

`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    // Reset value 1 makes requester 0 the first tie winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= 1'b1;
        end else if (w_frame_end) begin
            r_last_owner <= w_sel;
        end
    end

    assign w_winner = (req0_hdr_valid && req1_hdr_valid) ? ~r_last_owner : ~req0_hdr_valid;
`else
    assign w_winner = ~req0_hdr_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!tx_busy && w_any_req) begin
                        r_grant <= w_winner ? 2'b10 : 2'b01;
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (w_hdr_valid && tx_s_eth_hdr_ready) begin
                        r_state <= PAYLOAD;
                    end else if (!w_hdr_valid) begin
                        // Requester withdrew its header: abandon without passing any payload.
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end
                end
                PAYLOAD: begin
                    if (w_frame_end) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        tx_s_eth_hdr_valid           = 1'b0;
        tx_s_eth_dest_mac            = '0;
        tx_s_eth_src_mac             = '0;
        tx_s_eth_type                = '0;
        req0_hdr_ready               = 1'b0;
        req1_hdr_ready               = 1'b0;
        tx_s_eth_payload_axis_tdata  = '0;
        tx_s_eth_payload_axis_tvalid = 1'b0;
        tx_s_eth_payload_axis_tlast  = 1'b0;
        tx_s_eth_payload_axis_tuser  = 1'b0;
        req0_tready                  = 1'b0;
        req1_tready                  = 1'b0;
        if (r_state == HDR) begin
            tx_s_eth_hdr_valid = w_hdr_valid;
            tx_s_eth_dest_mac  = w_sel ? req1_dest_mac : req0_dest_mac;
            tx_s_eth_src_mac   = w_sel ? req1_src_mac : req0_src_mac;
            tx_s_eth_type      = w_sel ? req1_eth_type : req0_eth_type;
            req0_hdr_ready     = ~w_sel & tx_s_eth_hdr_ready;
            req1_hdr_ready     = w_sel & tx_s_eth_hdr_ready;
        end
        if (r_state == PAYLOAD) begin
            tx_s_eth_payload_axis_tdata  = w_sel ? req1_tdata : req0_tdata;
            tx_s_eth_payload_axis_tvalid = w_tvalid;
            tx_s_eth_payload_axis_tlast  = w_tlast;
            tx_s_eth_payload_axis_tuser  = w_sel ? req1_tuser : req0_tuser;
            req0_tready                  = ~w_sel & tx_s_eth_payload_axis_tready;
            req1_tready                  = w_sel & tx_s_eth_payload_axis_tready;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: single frames, tie ordering, backpressure, busy gating, reset and header abort.
module tb_eth_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_hdr_valid, req0_hdr_ready, req1_hdr_valid, req1_hdr_ready;
    logic [47:0] req0_dest_mac, req0_src_mac, req1_dest_mac, req1_src_mac;
    logic [15:0] req0_eth_type, req1_eth_type;
    logic [7:0]  req0_tdata, req1_tdata;
    logic        req0_tvalid, req0_tlast, req0_tuser, req0_tready;
    logic        req1_tvalid, req1_tlast, req1_tuser, req1_tready;
    logic        tx_s_eth_hdr_valid, tx_s_eth_hdr_ready;
    logic [47:0] tx_s_eth_dest_mac, tx_s_eth_src_mac;
    logic [15:0] tx_s_eth_type;
    logic [7:0]  tx_s_eth_payload_axis_tdata;
    logic        tx_s_eth_payload_axis_tvalid, tx_s_eth_payload_axis_tlast;
    logic        tx_s_eth_payload_axis_tuser, tx_s_eth_payload_axis_tready;
    logic        tx_busy;
    logic [1:0]  grant;

    int n_tests = 0;
    int n_fail  = 0;

    eth_tx_arbiter #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_hdr_valid(req0_hdr_valid), .req0_hdr_ready(req0_hdr_ready),
        .req0_dest_mac(req0_dest_mac), .req0_src_mac(req0_src_mac), .req0_eth_type(req0_eth_type),
        .req0_tdata(req0_tdata), .req0_tvalid(req0_tvalid), .req0_tlast(req0_tlast),
        .req0_tuser(req0_tuser), .req0_tready(req0_tready),
        .req1_hdr_valid(req1_hdr_valid), .req1_hdr_ready(req1_hdr_ready),
        .req1_dest_mac(req1_dest_mac), .req1_src_mac(req1_src_mac), .req1_eth_type(req1_eth_type),
        .req1_tdata(req1_tdata), .req1_tvalid(req1_tvalid), .req1_tlast(req1_tlast),
        .req1_tuser(req1_tuser), .req1_tready(req1_tready),
        .tx_s_eth_hdr_valid(tx_s_eth_hdr_valid), .tx_s_eth_hdr_ready(tx_s_eth_hdr_ready),
        .tx_s_eth_dest_mac(tx_s_eth_dest_mac), .tx_s_eth_src_mac(tx_s_eth_src_mac),
        .tx_s_eth_type(tx_s_eth_type),
        .tx_s_eth_payload_axis_tdata(tx_s_eth_payload_axis_tdata),
        .tx_s_eth_payload_axis_tvalid(tx_s_eth_payload_axis_tvalid),
        .tx_s_eth_payload_axis_tlast(tx_s_eth_payload_axis_tlast),
        .tx_s_eth_payload_axis_tuser(tx_s_eth_payload_axis_tuser),
        .tx_s_eth_payload_axis_tready(tx_s_eth_payload_axis_tready),
        .tx_busy(tx_busy), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a grant, checks owner and header, handshakes, then streams nb beats.
    task automatic serve(input logic [1:0] eg, input int nb, input string tag);
        int k = 0;
        while (grant == 2'b00 && k < 10) begin
            step();
            k++;
        end
        chk({tag, "_grant"}, grant, eg);
        chk({tag, "_hdr_valid"}, tx_s_eth_hdr_valid, 1);
        chk({tag, "_dest"}, tx_s_eth_dest_mac, eg[1] ? req1_dest_mac : req0_dest_mac);
        chk({tag, "_type"}, tx_s_eth_type, eg[1] ? req1_eth_type : req0_eth_type);
        step();
        if (eg[1]) req1_hdr_valid = 1'b0;
        else       req0_hdr_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            req0_tdata  = 8'(8'h10 + b);
            req1_tdata  = 8'(8'h20 + b);
            req0_tvalid = 1'b1;
            req1_tvalid = 1'b1;
            req0_tlast  = (b == nb - 1);
            req1_tlast  = (b == nb - 1);
            #1;
            chk({tag, "_tdata"}, tx_s_eth_payload_axis_tdata, eg[1] ? 8'h20 + b : 8'h10 + b);
            chk({tag, "_tlast"}, tx_s_eth_payload_axis_tlast, (b == nb - 1));
            step();
        end
        req0_tvalid = 1'b0; req1_tvalid = 1'b0;
        req0_tlast  = 1'b0; req1_tlast  = 1'b0;
        #1;
        chk({tag, "_grant_end"}, grant, 2'b00);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [6];
        int cnt0, cnt1, nb, cyc, exp_data;
        rst = 1'b1;
        req0_hdr_valid = 0; req1_hdr_valid = 0;
        req0_dest_mac = 48'h112233445566; req0_src_mac = 48'h020000000001; req0_eth_type = 16'h0800;
        req1_dest_mac = 48'hAABBCCDDEEFF; req1_src_mac = 48'h020000000002; req1_eth_type = 16'h86DD;
        req0_tdata = 0; req0_tvalid = 0; req0_tlast = 0; req0_tuser = 0;
        req1_tdata = 0; req1_tvalid = 0; req1_tlast = 0; req1_tuser = 0;
        tx_s_eth_hdr_ready = 1; tx_s_eth_payload_axis_tready = 1; tx_busy = 0;
        step();
        step();
        chk("rst_grant", grant, 2'b00);
        chk("rst_hdr_valid", tx_s_eth_hdr_valid, 0);
        chk("rst_tvalid", tx_s_eth_payload_axis_tvalid, 0);
        rst = 1'b0;

        // Single req0 frame: one-cycle arbitration latency then 4 beats.
        req0_hdr_valid = 1'b1;
        #1;
        chk("f0_grant_before_edge", grant, 2'b00);
        chk("f0_hdr_idle", tx_s_eth_hdr_valid, 0);
        step();
        chk("f0_grant_latency", grant, 2'b01);
        chk("f0_hdr_ready0", req0_hdr_ready, 1);
        chk("f0_hdr_ready1", req1_hdr_ready, 0);
        serve(2'b01, 4, "f0");

        // Simultaneous requests, three frames each.
        pulse_reset();
`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
        seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
`endif
        cnt0 = 0; cnt1 = 0;
        req0_hdr_valid = 1'b1; req1_hdr_valid = 1'b1;
        for (int f = 0; f < 6; f++) begin
            serve(seq[f], 2, "tie");
            if (seq[f][1]) cnt1++;
            else           cnt0++;
            req0_hdr_valid = (cnt0 < 3);
            req1_hdr_valid = (cnt1 < 3);
        end

        // req1 frame under toggling downstream ready.
        req1_hdr_valid = 1'b1;
        step();
        chk("bp_grant", grant, 2'b10);
        step();
        req1_hdr_valid = 1'b0;
        nb = 0; cyc = 0; exp_data = 8'h30;
        while (nb < 4 && cyc < 20) begin
            req1_tdata = 8'(8'h30 + nb);
            req1_tvalid = 1'b1;
            req1_tlast = (nb == 3);
            req0_tvalid = 1'b1;
            tx_s_eth_payload_axis_tready = (cyc % 2 == 0);
            #1;
            chk("bp_req1_tready", req1_tready, tx_s_eth_payload_axis_tready);
            chk("bp_req0_tready", req0_tready, 0);
            if (tx_s_eth_payload_axis_tvalid && tx_s_eth_payload_axis_tready) begin
                chk("bp_beat", tx_s_eth_payload_axis_tdata, exp_data);
                exp_data++;
                nb++;
            end
            step();
            cyc++;
        end
        chk("bp_beats_accepted", exp_data, 8'h34);
        req1_tvalid = 0; req1_tlast = 0; req0_tvalid = 0;
        tx_s_eth_payload_axis_tready = 1'b1;
        #1;
        chk("bp_grant_end", grant, 2'b00);

        // Busy blocks arbitration.
        tx_busy = 1'b1;
        req0_hdr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("busy_grant", grant, 2'b00);
        end
        tx_busy = 1'b0;
        step();
        chk("busy_release_grant", grant, 2'b01);
        serve(2'b01, 1, "busy");

        // Reset mid-payload with req1 pending.
        req0_hdr_valid = 1'b1;
        step();
        step();
        for (int b = 0; b < 2; b++) begin
            req0_tdata = 8'(8'h40 + b); req0_tvalid = 1'b1; req0_tlast = 1'b0;
            step();
        end
        req1_hdr_valid = 1'b1;
        req0_tdata = 8'h42;
        #1;
        chk("mid_tvalid_before_rst", tx_s_eth_payload_axis_tvalid, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_tvalid", tx_s_eth_payload_axis_tvalid, 0);
        chk("rst_mid_tready", req0_tready, 0);
        chk("rst_mid_grant", grant, 2'b00);
        step();
        rst = 1'b0;
        req0_tvalid = 1'b0;
        serve(2'b01, 1, "post_rst0");
        serve(2'b10, 1, "post_rst1");

        // req0 withdraws its header before the handshake.
        tx_s_eth_hdr_ready = 1'b0;
        req0_hdr_valid = 1'b1;
        req1_hdr_valid = 1'b1;
        step();
        chk("abort_grant", grant, 2'b01);
        chk("abort_hdr_ready", req0_hdr_ready, 0);
        req0_hdr_valid = 1'b0;
        req0_tvalid = 1'b1;
        #1;
        chk("abort_hdr_valid", tx_s_eth_hdr_valid, 0);
        step();
        chk("abort_grant_idle", grant, 2'b00);
        chk("abort_no_payload", tx_s_eth_payload_axis_tvalid, 0);
        req0_tvalid = 1'b0;
        tx_s_eth_hdr_ready = 1'b1;
        serve(2'b10, 2, "abort_req1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
